// File: rtl/mode_sequencer_pkg.sv
// Shared types and constants for the lab-board mode sequencer.
// Covers the controller state encoding, the active_mode codes and the mode field width.
package mode_sequencer_pkg;

  localparam int MODE_W = 5;

  localparam logic [2:0] ACT_HOME  = 3'd0;
  localparam logic [2:0] ACT_FAULT = 3'd7;

  typedef enum logic [2:0] {
    ST_HOME,
    ST_BLANK,
    ST_RUN,
    ST_PAUSE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/mode_sequencer_if.sv
// Switch inputs, slow tick and the ownership outputs of the mode sequencer.
// The board side drives through master; the sequencer sits on slave.
interface mode_sequencer_if #(
  parameter int NUM_MODES = mode_sequencer_pkg::MODE_W
);

  logic [NUM_MODES-1:0] mode_sw;
  logic                 pause_sw;
  logic                 tick;
  logic [NUM_MODES-1:0] mode_en;
  logic                 mode_clr;
  logic                 run_tick;
  logic                 blank;
  logic                 fault;
  logic [2:0]           active_mode;

  modport master (
    output mode_sw, pause_sw, tick,
    input  mode_en, mode_clr, run_tick, blank, fault, active_mode
  );

  modport slave (
    input  mode_sw, pause_sw, tick,
    output mode_en, mode_clr, run_tick, blank, fault, active_mode
  );

endinterface

// File: rtl/sw_stabilizer.sv
// Two-flop synchronizer plus a stability filter for a multi-bit switch field.
// A new code is accepted only after it has stayed constant for STABLE_CYCLES cycles.
module sw_stabilizer #(
  parameter int WIDTH         = 5,
  parameter int STABLE_CYCLES = 240000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] accepted,
  output logic             chg
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;

  // chg comes straight from registers and drops once accepted catches up.
  assign chg = (sync2 == prev) && (cnt == CNT_MAX) && (sync2 != accepted);

  // NOTE: every flop here updates with <= so all reads see pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      cnt      <= '0;
      accepted <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (chg) begin
        accepted <= sync2;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Lab-board mode controller: picks the owning functional unit from the filtered mode
// switches, blanks the display across mode changes and gates the slow tick.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int NUM_MODES     = MODE_W,
  parameter int STABLE_CYCLES = 240000,
  parameter int BLANK_CYCLES  = 2400000
) (
  input  logic               clock,
  input  logic               reset,
  mode_sequencer_if.slave    bus
);

  localparam int BW = $clog2(BLANK_CYCLES);
  localparam logic [NUM_MODES-1:0] ONE = NUM_MODES'(1);

  logic [NUM_MODES-1:0] accepted;
  logic                 chg;
  logic                 pause_s1;
  logic                 pause_s;
  logic                 is_onehot;
  logic [2:0]           mode_act;

  state_t               state;
  logic [BW-1:0]        bcnt;
  logic [NUM_MODES-1:0] mode_en;
  logic                 mode_clr;
  logic                 run_tick;
  logic                 blank;
  logic                 fault;
  logic [2:0]           active_mode;

  sw_stabilizer #(
    .WIDTH         (NUM_MODES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clock    (clock),
    .reset    (reset),
    .raw      (bus.mode_sw),
    .accepted (accepted),
    .chg      (chg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pause_s1 <= 1'b0;
      pause_s  <= 1'b0;
    end else begin
      pause_s1 <= bus.pause_sw;
      pause_s  <= pause_s1;
    end
  end

  // NOTE: both outputs get a default before the loop so no latch is inferred.
  always_comb begin
    is_onehot = 1'b0;
    mode_act  = ACT_HOME;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (accepted == (ONE << i)) begin
        is_onehot = 1'b1;
        mode_act  = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_HOME;
      bcnt        <= '0;
      mode_en     <= '0;
      mode_clr    <= 1'b0;
      run_tick    <= 1'b0;
      blank       <= 1'b0;
      fault       <= 1'b0;
      active_mode <= ACT_HOME;
    end else begin
      mode_clr <= 1'b0;
      // Qualified by the pre-edge state, so ticks on the RUN entry edge are lost.
      run_tick <= bus.tick && (state == ST_RUN);
      if (chg) begin
        state       <= ST_BLANK;
        bcnt        <= BW'(BLANK_CYCLES - 1);
        blank       <= 1'b1;
        mode_en     <= '0;
        fault       <= 1'b0;
        active_mode <= ACT_HOME;
      end else begin
        case (state)
          ST_BLANK: begin
            if (bcnt != '0) begin
              bcnt <= bcnt - BW'(1);
            end else if (accepted == '0) begin
              state       <= ST_HOME;
              blank       <= 1'b0;
              active_mode <= ACT_HOME;
            end else if (is_onehot) begin
              state       <= pause_s ? ST_PAUSE : ST_RUN;
              mode_en     <= accepted;
              mode_clr    <= 1'b1;
              blank       <= 1'b0;
              active_mode <= mode_act;
            end else begin
              state       <= ST_FAULT;
              fault       <= 1'b1;
              active_mode <= ACT_FAULT;
            end
          end
          ST_RUN:   if (pause_s)  state <= ST_PAUSE;
          ST_PAUSE: if (!pause_s) state <= ST_RUN;
          default: ;
        endcase
      end
    end
  end

  assign bus.mode_en     = mode_en;
  assign bus.mode_clr    = mode_clr;
  assign bus.run_tick    = run_tick;
  assign bus.blank       = blank;
  assign bus.fault       = fault;
  assign bus.active_mode = active_mode;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer with short filter and blanking intervals.
// A behavioural model built from sample histories is compared every cycle alongside directed checks.
module tb_mode_sequencer;

  localparam int NM = 5;
  localparam int ST = 4;
  localparam int BL = 8;
  localparam int HL = ST + 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mode_sequencer_if #(.NUM_MODES(NM)) bus ();

  mode_sequencer #(
    .NUM_MODES     (NM),
    .STABLE_CYCLES (ST),
    .BLANK_CYCLES  (BL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int rt_cnt = 0;
  int blank_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: raw sample histories (index 0 = newest) and the visible outputs.
  logic [NM-1:0] hist[$];
  logic          phist[$];
  logic [NM-1:0] m_acc;
  bit            m_blanking, m_owned, m_paused;
  int            m_left;
  logic [NM-1:0] m_en;
  logic          m_clr, m_rt, m_blank, m_fault;
  logic [2:0]    m_act;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist.delete();
      phist.delete();
      for (int i = 0; i < HL; i++) hist.push_back('0);
      for (int i = 0; i < 3; i++) phist.push_back(1'b0);
      m_acc = '0; m_blanking = 0; m_owned = 0; m_paused = 0; m_left = 0;
      m_en = '0; m_clr = 0; m_rt = 0; m_blank = 0; m_fault = 0; m_act = 3'd0;
    end else begin
      logic [NM-1:0] cand;
      bit steady, change, was_running, psync;
      hist.push_front(bus.mode_sw);
      void'(hist.pop_back());
      phist.push_front(bus.pause_sw);
      void'(phist.pop_back());
      cand   = hist[2];
      psync  = phist[2];
      steady = 1;
      for (int j = 2; j < HL; j++) if (hist[j] != cand) steady = 0;
      change = steady && (cand != m_acc);
      was_running = m_owned && !m_paused && !m_blanking;
      m_rt  = bus.tick && was_running;
      m_clr = 0;
      if (change) begin
        m_acc = cand; m_blanking = 1; m_left = BL - 1;
        m_blank = 1; m_en = '0; m_fault = 0; m_act = 3'd0;
        m_owned = 0; m_paused = 0;
      end else if (m_blanking) begin
        if (m_left > 0) m_left--;
        else begin
          m_blanking = 0;
          if (m_acc == '0) begin
            m_blank = 0; m_act = 3'd0;
          end else if ($countones(m_acc) == 1) begin
            m_owned = 1; m_paused = psync; m_en = m_acc; m_clr = 1;
            m_blank = 0; m_act = 3'($clog2(m_acc) + 1);
          end else begin
            m_fault = 1; m_act = 3'd7;
          end
        end
      end else if (m_owned) begin
        m_paused = psync;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("cycle_outputs",
            {20'd0, bus.mode_en, bus.mode_clr, bus.run_tick, bus.blank, bus.fault, bus.active_mode},
            {20'd0, m_en, m_clr, m_rt, m_blank, m_fault, m_act});
      clr_cnt   += int'(bus.mode_clr);
      rt_cnt    += int'(bus.run_tick);
      blank_cnt += int'(bus.blank);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_counts();
    clr_cnt = 0; rt_cnt = 0; blank_cnt = 0;
  endtask

  initial begin
    int lat;
    bus.mode_sw = '0; bus.pause_sw = 1'b0; bus.tick = 1'b0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;

    // Idle at home.
    clear_counts();
    step(12);
    check("home_mode_en", 32'(bus.mode_en), 0);
    check("home_active", 32'(bus.active_mode), 0);
    check("home_flags", {29'd0, bus.mode_clr, bus.run_tick, bus.fault}, 0);
    check("home_no_blank", blank_cnt, 0);

    // Select mode bit 2.
    clear_counts();
    bus.mode_sw = 5'b00100;
    lat = 0;
    while (bus.mode_en == '0 && lat < 40) begin
      step(1);
      lat++;
    end
    check("enter_latency", lat, 15);
    check("enter_blank_len", blank_cnt, 8);
    check("enter_mode_en", 32'(bus.mode_en), 32'h4);
    check("enter_clr", 32'(bus.mode_clr), 1);
    check("enter_active", 32'(bus.active_mode), 3);
    step(1);
    check("clr_one_cycle", 32'(bus.mode_clr), 0);
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    check("tick_forward", 32'(bus.run_tick), 1);
    step(1);
    check("tick_one_cycle", 32'(bus.run_tick), 0);
    check("enter_clr_count", clr_cnt, 1);

    // Short glitch on the mode field must be filtered.
    clear_counts();
    bus.mode_sw = 5'b01000;
    step(2);
    bus.mode_sw = 5'b00100;
    step(20);
    check("glitch_no_blank", blank_cnt, 0);
    check("glitch_mode_en", 32'(bus.mode_en), 32'h4);
    check("glitch_no_clr", clr_cnt, 0);

    // Pause drops ticks; resume forwards the next one.
    bus.pause_sw = 1'b1;
    step(4);
    clear_counts();
    repeat (3) begin
      bus.tick = 1'b1;
      step(1);
      bus.tick = 1'b0;
      step(2);
    end
    check("pause_drops_ticks", rt_cnt, 0);
    check("pause_holds_en", 32'(bus.mode_en), 32'h4);
    bus.pause_sw = 1'b0;
    step(4);
    clear_counts();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    check("resume_tick", 32'(bus.run_tick), 1);
    step(2);
    check("resume_tick_count", rt_cnt, 1);
    check("resume_no_clr", clr_cnt, 0);

    // Invalid code leads to fault, then back home.
    clear_counts();
    bus.mode_sw = 5'b00011;
    step(20);
    check("fault_flag", 32'(bus.fault), 1);
    check("fault_blank", 32'(bus.blank), 1);
    check("fault_mode_en", 32'(bus.mode_en), 0);
    check("fault_active", 32'(bus.active_mode), 7);
    check("fault_no_clr", clr_cnt, 0);
    bus.mode_sw = 5'b00000;
    step(20);
    check("unfault_flags", {30'd0, bus.fault, bus.blank}, 0);
    check("unfault_active", 32'(bus.active_mode), 0);
    check("unfault_mode_en", 32'(bus.mode_en), 0);

    // Change during blanking restarts the interval.
    clear_counts();
    bus.mode_sw = 5'b10000;
    step(5);
    bus.mode_sw = 5'b00010;
    lat = 5;
    while (bus.mode_en == '0 && lat < 60) begin
      step(1);
      lat++;
    end
    check("reblank_latency", lat, 20);
    check("reblank_len", blank_cnt, 13);
    check("reblank_mode_en", 32'(bus.mode_en), 32'h2);
    check("reblank_active", 32'(bus.active_mode), 2);
    step(3);
    check("reblank_clr_count", clr_cnt, 1);

    // Reset in the middle of blanking.
    bus.mode_sw = 5'b00001;
    step(10);
    check("pre_reset_blank", 32'(bus.blank), 1);
    reset = 1'b1;
    #1;
    check("reset_outputs",
          {20'd0, bus.mode_en, bus.mode_clr, bus.run_tick, bus.blank, bus.fault, bus.active_mode}, 0);
    step(2);
    reset = 1'b0;
    step(20);
    check("post_reset_mode_en", 32'(bus.mode_en), 32'h1);
    check("post_reset_active", 32'(bus.active_mode), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Top-level mode controller for the lab board. Filters the 5-bit slide-switch mode field and the pause switch, then decides which functional unit (hex echo, adder/multiplier, key counter, base-3 counter, scroller) owns the display and LEDs.
- On every mode change it runs a blanking interval and issues a one-cycle clear to the incoming unit.
- It gates the shared slow tick so only the running, unpaused unit advances.

Parameters:
- NUM_MODES, 5, width of the one-hot mode field and of mode_en.
- STABLE_CYCLES, 240000, cycles a synced mode code must stay constant before it is accepted (10 ms at 24 MHz).
- BLANK_CYCLES, 2400000, length of the blanking interval on a mode change (100 ms at 24 MHz). Must be ≥ 2.

Ports:
- clock, input, 1, system clock (24 MHz).
- reset, input, 1, asynchronous active-high reset.
- mode_sw, input, NUM_MODES, raw switch mode field (asynchronous).
- pause_sw, input, 1, raw pause switch (asynchronous, level).
- tick, input, 1, one-cycle strobe from the slow-tick prescaler.
- mode_en, output, NUM_MODES, one-hot enable of the owning unit. All-zero means none owns.
- mode_clr, output, 1, one-cycle clear pulse to the newly enabled unit.
- run_tick, output, 1, gated tick for the owning unit.
- blank, output, 1, high means force all hex digits off and LEDs off.
- fault, output, 1, high means an invalid mode code was accepted.
- active_mode, output, 3, 0 = home, k+1 = mode_en bit k, 7 = fault.

Behaviour:
- Reset value of all outputs is 0. The FSM resets to HOME and the accepted code resets to 0. Asserting reset mid-operation returns to this state immediately.
- mode_sw and pause_sw each pass through a 2-FF synchronizer.
- Stability filter:
  - The counter clears whenever the synced mode code differs from its previous-cycle value.
  - When the count reaches STABLE_CYCLES-1 and the synced code differs from the accepted code, the accepted code is updated and `chg` pulses for one cycle.
  - The counter saturates and does not wrap.
- Code classes:
  - 00000 → HOME.
  - Exactly one bit set → VALID(k).
  - Anything else → INVALID.
- FSM states: HOME, BLANK, RUN, PAUSE, FAULT.
  - Any state + chg → BLANK. On entry, load the blank counter with BLANK_CYCLES-1, set blank=1 and mode_en=0. A chg while already in BLANK reloads the counter.
  - BLANK, counter == 0, class HOME → HOME. blank=0, active_mode=0.
  - BLANK, counter == 0, class VALID(k) → RUN if synced pause == 0, otherwise PAUSE. On the transition edge: mode_en=bit k, mode_clr=1 for exactly one cycle, blank=0, active_mode=k+1.
  - BLANK, counter == 0, class INVALID → FAULT. fault=1, blank stays 1, active_mode=7.
  - RUN + synced pause == 1 → PAUSE. PAUSE + synced pause == 0 → RUN. mode_en is held in both states.
  - HOME and FAULT leave only on chg.
- run_tick: registered, so tick in cycle n produces run_tick in cycle n+1. It is asserted only if state == RUN in cycle n.
  - A tick coincident with the entry edge into RUN is dropped.
  - A tick in PAUSE is dropped, not stored.
- Priority: when chg and a pause change occur in the same cycle, chg wins.
- mode_clr and run_tick never assert in the same cycle.
- End-to-end latency from a mode_sw change to mode_en: 2 (sync) + STABLE_CYCLES + BLANK_CYCLES + 1 cycles, ±1.

Decomposition:
- Shared package holds:
  - the state enum (HOME, BLANK, RUN, PAUSE, FAULT);
  - active_mode encodings (ACT_HOME=0, ACT_FAULT=7);
  - the mode-code width constant.
- One sub-module, sw_stabilizer: a parameterised-width 2-FF sync plus the stability counter. It outputs the accepted code and the chg pulse.

Test Plan (run with STABLE_CYCLES=4, BLANK_CYCLES=8):
- Reset, then mode_sw=00000 held → all outputs 0, active_mode=0, no chg.
- mode_sw=00100 held → blank=1 for 8 cycles, then mode_en=00100, a single mode_clr pulse, active_mode=3. Next tick strobe → run_tick one cycle later.
- In RUN, glitch mode_sw to 01000 for 2 cycles then back to 00100 → no chg, mode_en unchanged, blank stays 0.
- In RUN, pause_sw=1 → PAUSE, 3 ticks give run_tick=0. pause_sw=0 → the next tick is forwarded, no mode_clr.
- mode_sw=00011 held → BLANK then FAULT: fault=1, blank=1, mode_en=0, active_mode=7. Then mode_sw=00000 → HOME, fault=0.
- During BLANK change mode_sw from 10000 to 00010 → blank counter restarts, final mode_en=00010, exactly one mode_clr. Assert reset during BLANK → all outputs 0 immediately.
